qam64_fifo_reader: RTL

Read-side consumer of the modulator's dual-clock byte FIFO, running entirely in the read clock domain. Pops bytes and unpacks the bitstream MSB-first into 6-bit 64QAM symbols. Maps each symbol to Gray-coded I/Q levels and zero-stuff upsamples by UPS. Feeds the pulse-shaping filter through a valid/ready stream.

---
 rtl/qam64_fifo_reader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/qam64_fifo_reader.sv
// -----------------------------------------------------------------------------
// qam64_fifo_reader
//
// Read-side consumer of the modulator's dual-clock byte FIFO. Everything here
// runs in the read clock domain. Bytes are popped from the FIFO and unpacked
// MSB-first into 6-bit 64QAM symbols. Each symbol is mapped to Gray-coded I/Q
// levels and zero-stuffed to UPS samples per symbol. The samples go to the
// pulse-shaping filter over a valid/ready stream.
//
// Parameters
//   UPS  samples per symbol (2..16)
//   IQW  signed width of i_out/q_out (>= 4)
//
// Ports
//   read_clk          clock, all logic on the rising edge
//   read_rst          synchronous active-high reset
//   en                run enable
//   fifo_empty        FIFO empty flag (read domain)
//   fifo_rd_data      FIFO data, valid the cycle after fifo_read_enable
//   fifo_read_enable  FIFO pop request
//   sym_ready         downstream ready
//   out_valid         sample valid
//   i_out / q_out     signed in-phase / quadrature sample
//   sym_strobe        high with the phase-0 (symbol-bearing) sample
//   underrun_cnt      saturating count of starvation events
// -----------------------------------------------------------------------------
module qam64_fifo_reader #(
  parameter int UPS = 4,
  parameter int IQW = 4
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_rd_data,
  output logic                  fifo_read_enable,
  input  logic                  sym_ready,
  output logic                  out_valid,
  output logic signed [IQW-1:0] i_out,
  output logic signed [IQW-1:0] q_out,
  output logic                  sym_strobe,
  output logic [7:0]            underrun_cnt
);

  localparam int            PW      = (UPS > 1) ? $clog2(UPS) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(UPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  // Gray-coded 3-bit group to odd amplitude level -7..+7.
  // The group is Gray-decoded to a binary index b, and the level is 2*b - 7.
  function automatic logic signed [IQW-1:0] gray_level(input logic [2:0] g);
    logic [2:0]        b;
    logic signed [4:0] lvl;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    lvl  = $signed({1'b0, b, 1'b1}) - 5'sd8;
    return IQW'(lvl);
  endfunction

  state_t                state_q, state_d;
  logic                  stop_q, stop_d;        // en dropped while in RUN
  logic [15:0]           acc_q, acc_d;          // left-justified bit reservoir
  logic [4:0]            bit_cnt_q, bit_cnt_d;  // valid bits in acc_q, 0..16
  logic [PW-1:0]         phase_q, phase_d;
  logic                  rd_pend_q;             // a FIFO byte returns this cycle
  logic                  out_valid_q, out_valid_d;
  logic signed [IQW-1:0] i_q, i_d;
  logic signed [IQW-1:0] q_q, q_d;
  logic                  strobe_q, strobe_d;
  logic [7:0]            underrun_q, underrun_d;

  logic                  rd_en;
  logic                  can_load;
  logic                  have_sym;
  logic                  load;
  logic                  consume;
  logic [15:0]           acc_shift;
  logic [4:0]            cnt_shift;
  logic [5:0]            sym;

  // A read is issued only when the reservoir can take a whole byte. At most
  // one read is in flight, so bit_cnt never exceeds 16.
  assign rd_en    = (state_q != IDLE) && !fifo_empty && !rd_pend_q &&
                    (bit_cnt_q <= 5'd8);
  assign can_load = !out_valid_q || sym_ready;
  assign have_sym = (bit_cnt_q >= 5'd6);
  assign sym      = acc_q[15:10];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no branch
    // below can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    stop_d      = stop_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    q_d         = q_q;
    strobe_d    = strobe_q;
    underrun_d  = underrun_q;
    load        = 1'b0;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (en) state_d = PRIME;
      end
      PRIME: begin
        // Phase is always 0 here; the first symbol is registered on the same
        // edge that moves us to RUN.
        if (can_load && have_sym) begin
          load    = 1'b1;
          consume = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) stop_d = 1'b1;
        if (can_load) begin
          if (phase_q != '0) begin
            load = 1'b1;
          end else if (stop_q || !en) begin
            // Symbol boundary reached after a stop request: leave the
            // reservoir intact and do not start a new symbol.
            state_d = IDLE;
          end else if (have_sym) begin
            load    = 1'b1;
            consume = 1'b1;
          end else begin
            state_d = PRIME;
            if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register: a free slot with nothing to load drains out_valid.
    if (can_load) begin
      out_valid_d = load;
      if (load) begin
        i_d      = consume ? gray_level(sym[5:3]) : '0;
        q_d      = consume ? gray_level(sym[2:0]) : '0;
        strobe_d = consume;
        phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      end
    end

    // Reservoir: consume the top 6 bits first, then append any returning byte
    // directly below the remaining valid bits.
    acc_shift = consume ? {acc_q[9:0], 6'b0} : acc_q;
    cnt_shift = consume ? bit_cnt_q - 5'd6 : bit_cnt_q;
    acc_d     = acc_shift;
    bit_cnt_d = cnt_shift;
    if (rd_pend_q) begin
      acc_d     = acc_shift | ({fifo_rd_data, 8'h00} >> cnt_shift);
      bit_cnt_d = cnt_shift + 5'd8;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      state_q     <= IDLE;
      stop_q      <= 1'b0;
      // NOTE: the bit reservoir is cleared with everything else; stale bits
      // would otherwise leak into the first symbol after reset.
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= '0;
      rd_pend_q   <= 1'b0;  // drops a byte returning right after reset
      out_valid_q <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      strobe_q    <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      rd_pend_q   <= rd_en;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      q_q         <= q_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign fifo_read_enable = rd_en;
  assign out_valid        = out_valid_q;
  assign i_out            = i_q;
  assign q_out            = q_q;
  assign sym_strobe       = strobe_q;
  assign underrun_cnt     = underrun_q;

endmodule
